z180_bus_sync: RTL and testbench



---
 rtl/z180_bus_sync.sv | 86 ++++++++
 tb/tb_z180_bus_sync.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/z180_bus_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// z180_bus_sync : button debouncer plus I/O read/write sample-point ticks
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module z180_bus_sync #(
  parameter int DEB_COUNT = 50000
) (
  input  logic phi,
  input  logic reset,
  input  logic btn_n,
  output logic btn_n_deb,
  input  logic iorq_n,
  input  logic rd_n,
  input  logic wr_n,
  output logic rd_tick,
  output logic wr_tick
);

  localparam int               CNT_W    = $clog2(DEB_COUNT);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_COUNT - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             btn_n_deb_q, btn_n_deb_d;
  logic [1:0]       rd_cnt_q, rd_cnt_d;
  logic [1:0]       wr_cnt_q, wr_cnt_d;
  logic             rd_qual;
  logic             wr_qual;

  assign rd_qual = ~iorq_n & ~rd_n;
  assign wr_qual = ~iorq_n & ~wr_n;

  // Debounce: the output only moves after DEB_COUNT consecutive clocks of
  // disagreement; any agreeing clock restarts the count.
  always_comb begin
    sync1_d     = btn_n;
    sync2_d     = sync1_q;
    deb_cnt_d   = '0;
    btn_n_deb_d = btn_n_deb_q;
    if (sync2_q != btn_n_deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        btn_n_deb_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + CNT_W'(1);
      end
    end
  end

  // Cycle counters saturate at 3 so long wait-stated cycles never re-tick.
  always_comb begin
    rd_cnt_d = 2'd0;
    wr_cnt_d = 2'd0;
    if (rd_qual) begin
      rd_cnt_d = (rd_cnt_q == 2'd3) ? 2'd3 : rd_cnt_q + 2'd1;
    end
    if (wr_qual) begin
      wr_cnt_d = (wr_cnt_q == 2'd3) ? 2'd3 : wr_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge phi) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      deb_cnt_q   <= '0;
      btn_n_deb_q <= 1'b1;
      rd_cnt_q    <= 2'd0;
      wr_cnt_q    <= 2'd0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_cnt_q   <= deb_cnt_d;
      btn_n_deb_q <= btn_n_deb_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
    end
  end

  assign btn_n_deb = btn_n_deb_q;
  assign rd_tick   = rd_qual & (rd_cnt_q == 2'd0) & ~reset;
  assign wr_tick   = wr_qual & (wr_cnt_q == 2'd1) & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_z180_bus_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_z180_bus_sync : directed vector bench for z180_bus_sync (DEB_COUNT = 4)
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module tb_z180_bus_sync;

  logic phi = 1'b0;
  logic reset;
  logic btn_n;
  logic btn_n_deb;
  logic iorq_n;
  logic rd_n;
  logic wr_n;
  logic rd_tick;
  logic wr_tick;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic iorq_n;
    logic rd_n;
    logic wr_n;
    logic reset;
    logic exp_rd;
    logic exp_wr;
  } vec_t;

  vec_t vq[$];

  z180_bus_sync #(.DEB_COUNT(4)) dut (
    .phi       (phi),
    .reset     (reset),
    .btn_n     (btn_n),
    .btn_n_deb (btn_n_deb),
    .iorq_n    (iorq_n),
    .rd_n      (rd_n),
    .wr_n      (wr_n),
    .rd_tick   (rd_tick),
    .wr_tick   (wr_tick)
  );

  always #5 phi = ~phi;

  task automatic check(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic add(input logic io, input logic rd, input logic wr, input logic rst,
                     input logic er, input logic ew);
    vq.push_back('{io, rd, wr, rst, er, ew});
  endtask

  task automatic tick_edge();
    @(posedge phi);
    #1;
  endtask

  initial begin
    // idle
    add(1, 1, 1, 0, 0, 0);
    // 4-clock read: tick in clock 1 only
    add(0, 0, 1, 0, 1, 0); add(0, 0, 1, 0, 0, 0); add(0, 0, 1, 0, 0, 0); add(0, 0, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0);
    // 3-clock write: tick in clock 2 only
    add(0, 1, 0, 0, 0, 0); add(0, 1, 0, 0, 0, 1); add(0, 1, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0);
    // 1-clock write: no tick
    add(0, 1, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0);
    // back-to-back 2-clock reads, ticks 3 clocks apart
    add(0, 0, 1, 0, 1, 0); add(0, 0, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0);
    add(0, 0, 1, 0, 1, 0); add(0, 0, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0);
    // 10-clock read: counter saturates, one tick
    add(0, 0, 1, 0, 1, 0);
    for (int i = 0; i < 9; i++) add(0, 0, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0);
    // illegal read+write together: independent ticks
    add(0, 0, 0, 0, 1, 0); add(0, 0, 0, 0, 0, 1); add(0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0);
    // reset mid-read: forced low during reset, tick on first clock after release
    add(0, 0, 1, 0, 1, 0); add(0, 0, 1, 1, 0, 0); add(0, 0, 1, 1, 0, 0);
    add(0, 0, 1, 0, 1, 0); add(0, 0, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0);
    // reset mid-write: wr_tick on second clock after release
    add(0, 1, 0, 0, 0, 0); add(0, 1, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0); add(0, 1, 0, 0, 0, 1); add(0, 1, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0);

    reset  = 1'b1;
    btn_n  = 1'b1;
    iorq_n = 1'b1;
    rd_n   = 1'b1;
    wr_n   = 1'b1;
    tick_edge();
    tick_edge();
    check("reset_deb", btn_n_deb, 1'b1);
    check("reset_rd_tick", rd_tick, 1'b0);
    check("reset_wr_tick", wr_tick, 1'b0);
    reset = 1'b0;

    // table: inputs set just after the edge, outputs sampled on the falling edge
    foreach (vq[i]) begin
      iorq_n = vq[i].iorq_n;
      rd_n   = vq[i].rd_n;
      wr_n   = vq[i].wr_n;
      reset  = vq[i].reset;
      @(negedge phi);
      check($sformatf("vec%0d_rd_tick", i), rd_tick, vq[i].exp_rd);
      check($sformatf("vec%0d_wr_tick", i), wr_tick, vq[i].exp_wr);
      tick_edge();
    end
    reset = 1'b0;

    // clean press: output falls on the 6th edge counting the first sampling edge
    btn_n = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick_edge();
      check($sformatf("press_edge%0d", k), btn_n_deb, (k >= 6) ? 1'b0 : 1'b1);
    end
    btn_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick_edge();
      check($sformatf("release_edge%0d", k), btn_n_deb, (k >= 6) ? 1'b1 : 1'b0);
    end

    // bounce: low 3 edges, high 1 edge, then low (final low edge is edge 5)
    btn_n = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick_edge();
      if (k == 3) btn_n = 1'b1;
      if (k == 4) btn_n = 1'b0;
      check($sformatf("bounce_edge%0d", k), btn_n_deb, (k >= 10) ? 1'b0 : 1'b1);
    end

    // reset during a read while the debounced button is low
    iorq_n = 1'b0;
    rd_n   = 1'b0;
    @(negedge phi);
    check("rstbtn_rd_clk1", rd_tick, 1'b1);
    tick_edge();
    reset = 1'b1;
    @(negedge phi);
    check("rstbtn_rd_in_reset", rd_tick, 1'b0);
    check("rstbtn_deb_before_edge", btn_n_deb, 1'b0);
    tick_edge();
    check("rstbtn_deb_in_reset", btn_n_deb, 1'b1);
    reset = 1'b0;
    @(negedge phi);
    check("rstbtn_rd_after_release", rd_tick, 1'b1);
    tick_edge();
    @(negedge phi);
    check("rstbtn_rd_clk2", rd_tick, 1'b0);
    iorq_n = 1'b1;
    rd_n   = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
